// File: rtl/bot_hs_pkg.sv
// Shared types and constants for the bot update/acknowledge handshake.
// Holds the channel state encoding, default widths and the info-word field positions.
package bot_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } ch_state_e;

  localparam int BOT_INFO_W = 32;
  localparam int BOT_MISS_W = 8;

  // Field layout of one channel's info word: {LocX, LocY, Sensors, BotInfo}
  localparam int LOCX_MSB    = 31;
  localparam int LOCX_LSB    = 24;
  localparam int LOCY_MSB    = 23;
  localparam int LOCY_LSB    = 16;
  localparam int SENSORS_MSB = 15;
  localparam int SENSORS_LSB = 8;
  localparam int BOTINFO_MSB = 7;
  localparam int BOTINFO_LSB = 0;

endpackage

// File: rtl/bot_upd_chan.sv
// One update channel: rising-edge event detect, IDLE/PEND FSM, optional info snapshot
// (BOT_SNAPSHOT_EN) and a saturating missed-update counter.
module bot_upd_chan
  import bot_hs_pkg::*;
#(
  parameter int INFO_W = BOT_INFO_W,
  parameter int MISS_W = BOT_MISS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_i,
  input  logic              ack_i,
  input  logic              clr_miss_i,
  input  logic [INFO_W-1:0] info_i,
  output logic              pending_o,
  output logic [INFO_W-1:0] info_o,
  output logic [MISS_W-1:0] miss_o
);

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  ch_state_e         state_q, state_d;
  logic              upd_q;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              ev;
  logic              ovf;

  assign ev = upd_i & ~upd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      upd_q   <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      upd_q   <= upd_i;
      miss_q  <= miss_d;
    end
  end

  // An event arriving together with an ack replaces the consumed one, so only
  // an event with no ack counts as an overflow.
  always_comb begin
    state_d = state_q;
    ovf     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev) state_d = PEND;
      end
      PEND: begin
        if (ev) begin
          ovf = ~ack_i;
        end else if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_d = miss_q;
    if (clr_miss_i) begin
      miss_d = MISS_W'(ovf);
    end else if (ovf && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  assign pending_o = (state_q == PEND);
  assign miss_o    = miss_q;

`ifdef BOT_SNAPSHOT_EN
  logic [INFO_W-1:0] snap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (ev) begin
      snap_q <= info_i;
    end
  end

  assign info_o = snap_q;
`else
  assign info_o = info_i;
`endif

endmodule

// File: rtl/bot_upd_handshake.sv
// NCH independent bot update/ack channels plus interrupt OR and lowest-index priority encoder.
// Define BOT_SNAPSHOT_EN to freeze each channel's info word at event time.
module bot_upd_handshake
  import bot_hs_pkg::*;
#(
  parameter int NCH    = 1,
  parameter int INFO_W = BOT_INFO_W,
  parameter int MISS_W = BOT_MISS_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH-1:0]                      upd_i,
  input  logic [NCH-1:0]                      ack_i,
  input  logic [NCH-1:0]                      clr_miss_i,
  input  logic [NCH*INFO_W-1:0]               info_i,
  output logic [NCH-1:0]                      pending_o,
  output logic                                irq_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] chan_o,
  output logic [NCH*INFO_W-1:0]               info_o,
  output logic [NCH*MISS_W-1:0]               miss_o
);

  localparam int CHAN_W = (NCH > 1) ? $clog2(NCH) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      bot_upd_chan #(
        .INFO_W(INFO_W),
        .MISS_W(MISS_W)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .upd_i     (upd_i[gi]),
        .ack_i     (ack_i[gi]),
        .clr_miss_i(clr_miss_i[gi]),
        .info_i    (info_i[gi*INFO_W +: INFO_W]),
        .pending_o (pending_o[gi]),
        .info_o    (info_o[gi*INFO_W +: INFO_W]),
        .miss_o    (miss_o[gi*MISS_W +: MISS_W])
      );
    end
  endgenerate

  assign irq_o = |pending_o;

  // Scan downwards so the lowest pending index is the last writer.
  always_comb begin
    chan_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_o[i]) chan_o = CHAN_W'(i);
    end
  end

endmodule

// File: tb/tb_bot_upd_handshake.sv
// Scoreboard bench for bot_upd_handshake (NCH=4, MISS_W=2): directed stimulus pushes
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_bot_upd_handshake;

  localparam int NCH    = 4;
  localparam int INFO_W = 32;
  localparam int MISS_W = 2;

  logic                  clk;
  logic                  rst;
  logic [NCH-1:0]        upd_r;
  logic [NCH-1:0]        ack_r;
  logic [NCH-1:0]        clr_r;
  logic [NCH*INFO_W-1:0] info_r;
  logic [NCH-1:0]        pending_w;
  logic                  irq_w;
  logic [1:0]            chan_w;
  logic [NCH*INFO_W-1:0] info_w;
  logic [NCH*MISS_W-1:0] miss_w;

  bot_upd_handshake #(
    .NCH   (NCH),
    .INFO_W(INFO_W),
    .MISS_W(MISS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_i     (upd_r),
    .ack_i     (ack_r),
    .clr_miss_i(clr_r),
    .info_i    (info_r),
    .pending_o (pending_w),
    .irq_o     (irq_w),
    .chan_o    (chan_w),
    .info_o    (info_w),
    .miss_o    (miss_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  pend;
    logic        irq;
    logic [1:0]  chan;
    int          ch;
    logic [31:0] info;
    logic [1:0]  miss;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Expected info depends on build: frozen snapshot, or the live producer word.
  task automatic push(input string name, input logic [3:0] pend, input logic [1:0] chan,
                      input int ch, input logic [31:0] snap, input logic [1:0] miss);
    exp_t e;
    e.name = name;
    e.pend = pend;
    e.irq  = |pend;
    e.chan = chan;
    e.ch   = ch;
`ifdef BOT_SNAPSHOT_EN
    e.info = snap;
`else
    e.info = info_r[ch*INFO_W +: INFO_W];
`endif
    e.miss = miss;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic [3:0] pend, input logic [1:0] chan,
                      input int ch, input logic [31:0] snap, input logic [1:0] miss);
    @(posedge clk);
    #1;
    push(name, pend, chan, ch, snap, miss);
    @(negedge clk);
    #1;
  endtask

  exp_t m;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      tests_run++;
      if (pending_w !== m.pend || irq_w !== m.irq || chan_w !== m.chan ||
          info_w[m.ch*INFO_W +: INFO_W] !== m.info || miss_w[m.ch*MISS_W +: MISS_W] !== m.miss) begin
        tests_failed++;
        $display("[TB] FAIL %s: got pend=%b irq=%b chan=%0d info[%0d]=%h miss=%0d, want pend=%b irq=%b chan=%0d info=%h miss=%0d",
                 m.name, pending_w, irq_w, chan_w, m.ch, info_w[m.ch*INFO_W +: INFO_W],
                 miss_w[m.ch*MISS_W +: MISS_W], m.pend, m.irq, m.chan, m.info, m.miss);
      end else begin
        $display("[TB] ok   %s: pend=%b chan=%0d info=%h miss=%0d",
                 m.name, pending_w, chan_w, m.info, m.miss);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] miss_vals[3];
  logic [1:0]  sat_tab[5];

  initial begin
    miss_vals = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
    sat_tab   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst    = 1'b1;
    upd_r  = '0;
    ack_r  = '0;
    clr_r  = '0;
    info_r = '0;
    repeat (3) @(negedge clk);
    #1;
    push("reset", 4'b0000, 2'd0, 0, 32'h0, 2'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Single rise held high: exactly one event
    info_r[31:0] = 32'h1122_3344;
    upd_r[0] = 1'b1;
    step("rise", 4'b0001, 2'd0, 0, 32'h1122_3344, 2'd0);
    for (int i = 0; i < 4; i++) step("hold", 4'b0001, 2'd0, 0, 32'h1122_3344, 2'd0);
    upd_r[0] = 1'b0;
    step("fall", 4'b0001, 2'd0, 0, 32'h1122_3344, 2'd0);

    // Three overflow events, latest info wins
    for (int i = 0; i < 3; i++) begin
      info_r[31:0] = miss_vals[i];
      upd_r[0] = 1'b1;
      step("miss_ev", 4'b0001, 2'd0, 0, miss_vals[i], 2'(i + 1));
      upd_r[0] = 1'b0;
      step("miss_low", 4'b0001, 2'd0, 0, miss_vals[i], 2'(i + 1));
    end
    ack_r[0] = 1'b1;
    step("ack", 4'b0000, 2'd0, 0, 32'h0000_000C, 2'd3);
    ack_r[0] = 1'b0;
    clr_r[0] = 1'b1;
    step("clr_miss", 4'b0000, 2'd0, 0, 32'h0000_000C, 2'd0);
    clr_r[0] = 1'b0;

    // Ack while idle is ignored
    info_r[31:0] = 32'h0000_000F;
    ack_r[0] = 1'b1;
    step("idle_ack", 4'b0000, 2'd0, 0, 32'h0000_000C, 2'd0);
    ack_r[0] = 1'b0;

    // Event and ack coincide while pending
    info_r[31:0] = 32'h0000_000D;
    upd_r[0] = 1'b1;
    step("ev_d", 4'b0001, 2'd0, 0, 32'h0000_000D, 2'd0);
    upd_r[0] = 1'b0;
    step("ev_d_low", 4'b0001, 2'd0, 0, 32'h0000_000D, 2'd0);
    info_r[31:0] = 32'h0000_000E;
    upd_r[0] = 1'b1;
    ack_r[0] = 1'b1;
    step("ev_ack", 4'b0001, 2'd0, 0, 32'h0000_000E, 2'd0);
    upd_r[0] = 1'b0;
    ack_r[0] = 1'b0;
    step("ev_ack_hold", 4'b0001, 2'd0, 0, 32'h0000_000E, 2'd0);

    // Saturation at 3, then clear coincident with an overflow
    for (int i = 0; i < 5; i++) begin
      info_r[31:0] = 32'h100 + 32'(i);
      upd_r[0] = 1'b1;
      step("sat_ev", 4'b0001, 2'd0, 0, 32'h100 + 32'(i), sat_tab[i]);
      upd_r[0] = 1'b0;
      step("sat_low", 4'b0001, 2'd0, 0, 32'h100 + 32'(i), sat_tab[i]);
    end
    info_r[31:0] = 32'h0000_0200;
    upd_r[0] = 1'b1;
    clr_r[0] = 1'b1;
    step("clr_ovf", 4'b0001, 2'd0, 0, 32'h0000_0200, 2'd1);
    upd_r[0] = 1'b0;
    clr_r[0] = 1'b0;
    ack_r[0] = 1'b1;
    step("ack_sat", 4'b0000, 2'd0, 0, 32'h0000_0200, 2'd1);
    ack_r[0] = 1'b0;

    // Multi-channel priority
    info_r[2*INFO_W +: INFO_W] = 32'h0000_0022;
    info_r[3*INFO_W +: INFO_W] = 32'h0000_0033;
    upd_r = 4'b1100;
    step("multi", 4'b1100, 2'd2, 2, 32'h0000_0022, 2'd0);
    upd_r = 4'b0000;
    ack_r = 4'b0100;
    step("ack_ch2", 4'b1000, 2'd3, 3, 32'h0000_0033, 2'd0);
    ack_r = 4'b1000;
    step("ack_ch3", 4'b0000, 2'd0, 3, 32'h0000_0033, 2'd0);
    ack_r = 4'b0000;

    // Async reset mid-cycle while pending with upd held high
    info_r[31:0] = 32'h0000_0055;
    upd_r[0] = 1'b1;
    step("pre_rst", 4'b0001, 2'd0, 0, 32'h0000_0055, 2'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    push("async_rst", 4'b0000, 2'd0, 0, 32'h0, 2'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 4'b0001, 2'd0, 0, 32'h0000_0055, 2'd0);
    step("post_rst_hold", 4'b0001, 2'd0, 0, 32'h0000_0055, 2'd0);
    info_r[31:0] = 32'h0000_0066;
    #1;
    push("info_track", 4'b0001, 2'd0, 0, 32'h0000_0055, 2'd0);
    @(negedge clk);
    #1;

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
